dzcpu_useq: RTL and testbench

DZCPU_USEQ -- requirements
Module: dzcpu_useq

---
 rtl/dzcpu_useq.sv | 172 +++++++++++++++++
 tb/tb_dzcpu_useq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_useq.sv
// rtl/dzcpu_useq.sv - microcode sequencer for the dzcpu core
//
// Walks microcode flows held in an external ROM. In FETCH the sequencer
// waits for a fetched opcode (iMopValid) and jumps to its flow, or to the
// interrupt entry flow when an interrupt is pending and enabled. In EXEC it
// presents rUpc on oUopAddr, retires one uop per unstalled cycle, raises
// the PC-increment and flag-update strobes from the uop flow field and
// returns to FETCH when the flow ends.
//
// Ports:
//   iClock        clock, rising edge
//   iReset        asynchronous active-low reset
//   iMopValid     opcode byte present on the LUT inputs this cycle
//   iFlowIdx      main LUT flow index
//   iCbFlowIdx    CB-prefix LUT flow index (target of jcb)
//   iUop          ROM word at oUopAddr: flow [12:9], op [8:4], operand [3:0]
//   iStall        memory or datapath busy; freezes the sequencer
//   iFlagZ        current Z flag, used by the conditional end codes
//   iIntReq       interrupt pending
//   iIme          interrupt master enable
//   oUopAddr      registered ROM address (rUpc)
//   oUopValid     datapath executes iUop this cycle
//   oIncPc        PC-increment strobe
//   oUpdateFlags  flag-update strobe
//   oMopDone      one-cycle pulse on the last uop of a flow
//   oIntAck       one-cycle pulse when the interrupt flow is entered
//   oFault        sticky runaway-flow indicator, cleared only by reset
module dzcpu_useq #(
  parameter logic [7:0] INT_FLOW_IDX = 8'd238,
  parameter logic [7:0] MAX_FLOW_LEN = 8'd32,
  parameter logic [4:0] JCB_OP       = 5'h1E
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iMopValid,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  input  logic [12:0] iUop,
  input  logic        iStall,
  input  logic        iFlagZ,
  input  logic        iIntReq,
  input  logic        iIme,
  output logic [7:0]  oUopAddr,
  output logic        oUopValid,
  output logic        oIncPc,
  output logic        oUpdateFlags,
  output logic        oMopDone,
  output logic        oIntAck,
  output logic        oFault
);

  localparam logic ST_FETCH = 1'b0;
  localparam logic ST_EXEC  = 1'b1;

  localparam logic [3:0] FL_OP         = 4'd0;
  localparam logic [3:0] FL_INC        = 4'd1;
  localparam logic [3:0] FL_EOF        = 4'd2;
  localparam logic [3:0] FL_INC_EOF    = 4'd3;
  localparam logic [3:0] FL_EOF_FU     = 4'd4;
  localparam logic [3:0] FL_INC_EOF_FU = 4'd5;
  localparam logic [3:0] FL_INC_EOF_Z  = 4'd6;
  localparam logic [3:0] FL_INC_EOF_NZ = 4'd7;
  localparam logic [3:0] FL_UPD_FLAGS  = 4'd8;

  logic       state_q, state_d;
  logic [7:0] upc_q, upc_d;
  logic [7:0] len_q, len_d;
  logic       fault_q, fault_d;

  logic [3:0] flow_code;
  logic [4:0] op_code;
  logic       dec_inc, dec_upd, dec_end;
  logic       uop_valid, inc_pc, upd_flags, mop_done, int_ack;
  logic [7:0] len_next;

  // Operand bits belong to the datapath only.
  logic unused_operand;
  assign unused_operand = ^iUop[3:0];

  assign flow_code = iUop[12:9];
  assign op_code   = iUop[8:4];
  assign len_next  = len_q + 8'd1;

  // Flow field decode; codes 9-15 behave like a plain op.
  always_comb begin
    dec_inc = 1'b0;
    dec_upd = 1'b0;
    dec_end = 1'b0;
    case (flow_code)
      FL_INC:        dec_inc = 1'b1;
      FL_EOF:        dec_end = 1'b1;
      FL_INC_EOF:    begin dec_inc = 1'b1; dec_end = 1'b1; end
      FL_EOF_FU:     begin dec_upd = 1'b1; dec_end = 1'b1; end
      FL_INC_EOF_FU: begin dec_inc = 1'b1; dec_upd = 1'b1; dec_end = 1'b1; end
      FL_INC_EOF_Z:  begin dec_inc = 1'b1; dec_end = iFlagZ;  end
      FL_INC_EOF_NZ: begin dec_inc = 1'b1; dec_end = !iFlagZ; end
      FL_UPD_FLAGS:  dec_upd = 1'b1;
      default:       dec_inc = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    len_d     = len_q;
    fault_d   = fault_q;
    uop_valid = (state_q == ST_EXEC) && !iStall;
    inc_pc    = 1'b0;
    upd_flags = 1'b0;
    mop_done  = 1'b0;
    int_ack   = 1'b0;

    if (state_q == ST_FETCH) begin
      // Interrupts are only sampled here, so a flow is never cut short.
      if (iMopValid) begin
        if (iIntReq && iIme) begin
          upc_d   = INT_FLOW_IDX;
          int_ack = 1'b1;
        end else begin
          upc_d   = iFlowIdx;
        end
        len_d   = 8'd0;
        state_d = ST_EXEC;
      end
    end else if (uop_valid) begin
      inc_pc    = dec_inc;
      upd_flags = dec_upd;
      if (dec_end) begin
        // End of flow wins over a jcb in the same uop.
        mop_done = 1'b1;
        state_d  = ST_FETCH;
      end else if (len_next == MAX_FLOW_LEN) begin
        fault_d = 1'b1;
        state_d = ST_FETCH;
      end else if (op_code == JCB_OP) begin
        upc_d = iCbFlowIdx;
        len_d = len_next;
      end else if (upc_q == 8'hFF) begin
        // Running off the end of the ROM: stop rather than wrap to 0.
        fault_d = 1'b1;
        state_d = ST_FETCH;
      end else begin
        upc_d = upc_q + 8'd1;
        len_d = len_next;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= ST_FETCH;
      upc_q   <= 8'd0;
      len_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      len_q   <= len_d;
      fault_q <= fault_d;
    end
  end

  assign oUopAddr     = upc_q;
  assign oUopValid    = uop_valid;
  assign oIncPc       = inc_pc;
  assign oUpdateFlags = upd_flags;
  assign oMopDone     = mop_done;
  // The ack is decoded from live inputs in FETCH, so hold it low in reset.
  assign oIntAck      = int_ack && iReset;
  assign oFault       = fault_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb/tb_dzcpu_useq.sv - directed-vector bench for dzcpu_useq
module tb_dzcpu_useq;

  localparam logic [4:0] JCB = 5'h1E;

  logic        iClock;
  logic        iReset;
  logic        iMopValid;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [12:0] iUop;
  logic        iStall;
  logic        iFlagZ;
  logic        iIntReq;
  logic        iIme;
  logic [7:0]  oUopAddr;
  logic        oUopValid;
  logic        oIncPc;
  logic        oUpdateFlags;
  logic        oMopDone;
  logic        oIntAck;
  logic        oFault;

  logic [12:0] rom [256];
  int n_vec;
  int n_err;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMopValid(iMopValid),
    .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .iUop(iUop),
    .iStall(iStall), .iFlagZ(iFlagZ), .iIntReq(iIntReq), .iIme(iIme),
    .oUopAddr(oUopAddr), .oUopValid(oUopValid), .oIncPc(oIncPc),
    .oUpdateFlags(oUpdateFlags), .oMopDone(oMopDone), .oIntAck(oIntAck),
    .oFault(oFault)
  );

  assign iUop = rom[oUopAddr];

  // {addr, valid, inc_pc, update_flags, mop_done, int_ack, fault}
  logic [13:0] obs;
  assign obs = {oUopAddr, oUopValid, oIncPc, oUpdateFlags, oMopDone, oIntAck, oFault};

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  function automatic logic [12:0] mk(input logic [3:0] f, input logic [4:0] op);
    return {f, op, 4'h5};
  endfunction

  // Returns at negedge+1 of the first uop cycle.
  task automatic start_flow(input logic [7:0] idx);
    @(negedge iClock);
    iFlowIdx  = idx;
    iMopValid = 1'b1;
    @(negedge iClock);
    iMopValid = 1'b0;
    #1;
  endtask

  task automatic step;
    @(negedge iClock);
    #1;
  endtask

  task automatic test_reset;
    logic [13:0] exp;
    repeat (2) @(negedge iClock);
    iMopValid = 1'b1; iIntReq = 1'b1; iIme = 1'b1; iFlowIdx = 8'd9;
    #1;
    exp = 14'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_hold got %h want %h", obs, exp); end
    @(negedge iClock);
    iMopValid = 1'b0; iIntReq = 1'b0; iIme = 1'b0;
    iReset = 1'b1;
    step();
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_idle got %h want %h", obs, exp); end
  endtask

  task automatic test_basic;
    logic [13:0] exp;
    logic [3:0]  incp;
    incp = 4'b1011;
    start_flow(8'd1);
    for (int k = 0; k < 4; k++) begin
      exp = {8'(k + 1), 1'b1, incp[k], 1'b0, (k == 3), 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL basic_uop k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    exp = {8'd4, 6'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL basic_fetch got %h want %h", obs, exp); end
  endtask

  task automatic test_cond_eof;
    logic [13:0] exp;
    int n;
    for (int z = 1; z >= 0; z--) begin
      iFlagZ = (z == 1);
      n = (z == 1) ? 3 : 6;
      start_flow(8'd17);
      for (int k = 0; k < n; k++) begin
        exp = {8'(17 + k), 1'b1, (k == 0 || k == 2), 1'b0, (k == n - 1), 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL cond_z%0d k=%0d got %h want %h", z, k, obs, exp); end
        step();
      end
      exp = {8'(17 + n - 1), 6'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL cond_fetch_z%0d got %h want %h", z, obs, exp); end
    end
    iFlagZ = 1'b0;
  endtask

  task automatic test_jcb;
    logic [13:0] exp;
    logic [3:0]  incp, ufp;
    incp = 4'b1101;
    ufp  = 4'b0010;
    iCbFlowIdx = 8'd16;
    start_flow(8'd13);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) iCbFlowIdx = 8'd80;
      #1;
      exp = {8'(13 + k), 1'b1, incp[k], ufp[k], (k == 3), 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL jcb_uop k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    exp = {8'd16, 6'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL jcb_eof_prio got %h want %h", obs, exp); end
    start_flow(8'd90);
    exp = {8'd90, 1'b1, 5'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL jcb_op got %h want %h", obs, exp); end
    step();
    exp = {8'd80, 1'b1, 1'b0, 1'b0, 1'b1, 2'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL jcb_target got %h want %h", obs, exp); end
  endtask

  task automatic test_interrupt;
    logic [13:0] exp;
    start_flow(8'd60);
    iIntReq = 1'b1; iIme = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp = {8'(60 + k), 1'b1, (k == 0), 1'b0, (k == 2), 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL int_defer k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    iMopValid = 1'b1; iFlowIdx = 8'd70;
    #1;
    exp = {8'd62, 1'b0, 3'b0, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL int_ack got %h want %h", obs, exp); end
    @(negedge iClock);
    iMopValid = 1'b0;
    #1;
    exp = {8'd238, 1'b1, 2'b0, 1'b1, 2'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL int_entry got %h want %h", obs, exp); end
    step();
    iIme = 1'b0;
    iMopValid = 1'b1; iFlowIdx = 8'd70;
    #1;
    exp = {8'd238, 6'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL int_masked_ack got %h want %h", obs, exp); end
    @(negedge iClock);
    iMopValid = 1'b0;
    #1;
    exp = {8'd70, 1'b1, 2'b0, 1'b1, 2'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL int_masked_flow got %h want %h", obs, exp); end
    iIntReq = 1'b0;
    step();
  endtask

  task automatic test_stall;
    logic [13:0] exp;
    start_flow(8'd50);
    exp = {8'd50, 1'b1, 1'b1, 4'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL stall_pre got %h want %h", obs, exp); end
    step();
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp = {8'd51, 6'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL stall_hold k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    iStall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp = {8'(51 + k), 1'b1, 1'b1, (k == 2), (k == 2), 2'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL stall_resume k=%0d got %h want %h", k, obs, exp); end
      step();
    end
  endtask

  task automatic test_fault_len;
    logic [13:0] exp;
    start_flow(8'd100);
    for (int k = 0; k < 32; k++) begin
      exp = {8'(100 + k), 1'b1, 1'b1, 4'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL len_uop k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      exp = {8'd131, 5'b0, 1'b1};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL len_fault k=%0d got %h want %h", k, obs, exp); end
      step();
    end
  endtask

  task automatic test_reset_mid;
    logic [13:0] exp;
    @(negedge iClock);
    iReset = 1'b0;
    #1;
    exp = 14'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL fault_clear got %h want %h", obs, exp); end
    @(negedge iClock);
    iReset = 1'b1;
    start_flow(8'd100);
    step();
    step();
    exp = {8'd102, 1'b1, 1'b1, 4'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL mid_pre got %h want %h", obs, exp); end
    iReset = 1'b0;
    #1;
    exp = 14'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL mid_reset got %h want %h", obs, exp); end
    @(negedge iClock);
    iReset = 1'b1;
    step();
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL mid_release got %h want %h", obs, exp); end
    start_flow(8'd1);
    exp = {8'd1, 1'b1, 1'b1, 4'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL mid_restart got %h want %h", obs, exp); end
    repeat (4) step();
  endtask

  task automatic test_fault_wrap;
    logic [13:0] exp;
    start_flow(8'd254);
    for (int k = 0; k < 2; k++) begin
      exp = {8'(254 + k), 1'b1, 5'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL wrap_uop k=%0d got %h want %h", k, obs, exp); end
      step();
    end
    exp = {8'd255, 5'b0, 1'b1};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL wrap_fault got %h want %h", obs, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    iReset = 1'b0; iMopValid = 1'b0; iFlowIdx = 8'd0; iCbFlowIdx = 8'd0;
    iStall = 1'b0; iFlagZ = 1'b0; iIntReq = 1'b0; iIme = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = mk(4'd0, 5'd0);
    rom[1]  = mk(4'd1, 5'd0);  rom[2]  = mk(4'd1, 5'd0);
    rom[3]  = mk(4'd0, 5'd0);  rom[4]  = mk(4'd3, 5'd0);
    rom[13] = mk(4'd1, 5'd0);  rom[14] = mk(4'd8, 5'd0);
    rom[15] = mk(4'd1, JCB);   rom[16] = mk(4'd3, JCB);
    rom[17] = mk(4'd1, 5'd0);  rom[18] = mk(4'd0, 5'd0);
    rom[19] = mk(4'd6, 5'd0);  rom[20] = mk(4'd0, 5'd0);
    rom[21] = mk(4'd0, 5'd0);  rom[22] = mk(4'd2, 5'd0);
    rom[50] = mk(4'd1, 5'd0);  rom[51] = mk(4'd1, 5'd0);
    rom[52] = mk(4'd1, 5'd0);  rom[53] = mk(4'd5, 5'd0);
    rom[60] = mk(4'd1, 5'd0);  rom[61] = mk(4'd0, 5'd0);
    rom[62] = mk(4'd2, 5'd0);  rom[70] = mk(4'd2, 5'd0);
    rom[80] = mk(4'd2, 5'd0);  rom[90] = mk(4'd0, JCB);
    rom[238] = mk(4'd2, 5'd0);
    for (int i = 100; i < 140; i++) rom[i] = mk(4'd1, 5'd0);

    test_reset();
    test_basic();
    test_cond_eof();
    test_jcb();
    test_interrupt();
    test_stall();
    test_fault_len();
    test_reset_mid();
    test_fault_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
